// File: rtl/full_adder_cell_if.sv
// Operand, control and result signals of the full adder cell, grouped so the
// datapath can hook a cell up with a single connection.
interface full_adder_cell_if;
    logic a_i;
    logic b_i;
    logic cin_i;
    logic valid_i;
    logic serial_en_i;
    logic clear_i;

    logic s_o;
    logic cout_o;
    logic p_o;
    logic g_o;
    logic s_q_o;
    logic cout_q_o;
    logic valid_o;

    modport master (
        output a_i,
        output b_i,
        output cin_i,
        output valid_i,
        output serial_en_i,
        output clear_i,
        input  s_o,
        input  cout_o,
        input  p_o,
        input  g_o,
        input  s_q_o,
        input  cout_q_o,
        input  valid_o
    );

    modport slave (
        input  a_i,
        input  b_i,
        input  cin_i,
        input  valid_i,
        input  serial_en_i,
        input  clear_i,
        output s_o,
        output cout_o,
        output p_o,
        output g_o,
        output s_q_o,
        output cout_q_o,
        output valid_o
    );
endinterface

// File: rtl/full_adder_cell.sv
// Single-bit full adder with an optional registered stage whose carry register
// lets the cell add or subtract a word bit-serially, LSB first.
module full_adder_cell #(
    parameter bit REG_OUT = 1'b1
) (
    input logic            clk_i,
    input logic            rst_ni,
    full_adder_cell_if.slave bus
);

    logic prop;
    logic gen;
    logic carry_q;

    assign prop       = bus.a_i ^ bus.b_i;
    assign gen        = bus.a_i & bus.b_i;
    assign bus.p_o    = prop;
    assign bus.g_o    = gen;
    assign bus.s_o    = prop ^ bus.cin_i;
    assign bus.cout_o = gen | (bus.cin_i & prop);

    generate
        if (REG_OUT) begin : g_reg
            logic c_eff;
            logic s_r;
            logic c_r;
            logic s_q;
            logic cout_q;
            logic valid_q;

            // clear_i marks a new word, so the first bit always takes cin_i
            assign c_eff = (bus.serial_en_i & ~bus.clear_i) ? carry_q : bus.cin_i;
            assign s_r   = prop ^ c_eff;
            assign c_r   = gen | (c_eff & prop);

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    s_q     <= 1'b0;
                    cout_q  <= 1'b0;
                    carry_q <= 1'b0;
                    valid_q <= 1'b0;
                end else if (bus.valid_i) begin
                    s_q     <= s_r;
                    cout_q  <= c_r;
                    carry_q <= c_r;
                    valid_q <= 1'b1;
                end else begin
                    valid_q <= 1'b0;
                    if (bus.clear_i) begin
                        carry_q <= 1'b0;
                    end
                end
            end

            assign bus.s_q_o    = s_q;
            assign bus.cout_q_o = cout_q;
            assign bus.valid_o  = valid_q;
        end else begin : g_noreg
            assign carry_q      = 1'b0;
            assign bus.s_q_o    = 1'b0;
            assign bus.cout_q_o = 1'b0;
            assign bus.valid_o  = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_full_adder_cell.sv
// Self-checking bench for full_adder_cell: combinational truth table, pipelined
// and bit-serial add/subtract, async reset and carry clearing.
module tb_full_adder_cell;

    typedef struct packed {
        logic s;
        logic c;
        logic v;
    } exp_t;

    logic clk_i;
    logic rst_ni;
    int   assertCount;
    int   failCount;
    exp_t scoreboard[$];
    logic modelCarry;
    logic modelS;
    logic modelC;
    logic [7:0] wordResult;

    full_adder_cell_if bus ();

    full_adder_cell #(.REG_OUT(1'b1)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of stimulus, checks the combinational outputs at once and
    // the registered outputs one edge later against the scoreboard entry.
    task automatic applyStimulus(input logic a, input logic b, input logic cin,
                                 input logic valid, input logic ser, input logic clr);
        logic [1:0] sum;
        logic       cEff;
        exp_t       e;
        bus.a_i = a; bus.b_i = b; bus.cin_i = cin;
        bus.valid_i = valid; bus.serial_en_i = ser; bus.clear_i = clr;
        #1;
        sum = 2'(a) + 2'(b) + 2'(cin);
        checkOutput("comb_s", 32'(bus.s_o), 32'(sum[0]));
        checkOutput("comb_cout", 32'(bus.cout_o), 32'(sum[1]));
        checkOutput("comb_p", 32'(bus.p_o), 32'(a != b));
        checkOutput("comb_g", 32'(bus.g_o), 32'(a && b));

        cEff = (ser && !clr) ? modelCarry : cin;
        sum  = 2'(a) + 2'(b) + 2'(cEff);
        if (valid) begin
            modelS = sum[0];
            modelC = sum[1];
            modelCarry = sum[1];
        end else if (clr) begin
            modelCarry = 1'b0;
        end
        e.s = modelS; e.c = modelC; e.v = valid;
        scoreboard.push_back(e);

        @(posedge clk_i);
        #1;
        e = scoreboard.pop_front();
        checkOutput("reg_s", 32'(bus.s_q_o), 32'(e.s));
        checkOutput("reg_cout", 32'(bus.cout_q_o), 32'(e.c));
        checkOutput("reg_valid", 32'(bus.valid_o), 32'(e.v));
        checkOutput("carry_q", 32'(dut.carry_q), 32'(modelCarry));
    endtask

    task automatic serialWord(input logic [7:0] a, input logic [7:0] b, input logic cin);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(a[i], b[i], cin, 1'b1, 1'b1, i == 0);
            wordResult[i] = bus.s_q_o;
        end
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        modelCarry  = 1'b0;
        modelS      = 1'b0;
        modelC      = 1'b0;
        bus.a_i = 0; bus.b_i = 0; bus.cin_i = 0;
        bus.valid_i = 0; bus.serial_en_i = 0; bus.clear_i = 0;
        rst_ni = 1'b0;
        #1;
        checkOutput("reset_s", 32'(bus.s_q_o), 32'd0);
        checkOutput("reset_cout", 32'(bus.cout_q_o), 32'd0);
        checkOutput("reset_valid", 32'(bus.valid_o), 32'd0);
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;

        $display("[TB] exhaustive combinational truth table");
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            applyStimulus(v[2], v[1], v[0], 1'b0, 1'b0, 1'b0);
        end
        bus.a_i = 1; bus.b_i = 1; bus.cin_i = 1;
        #1;
        checkOutput("tt_111_s", 32'(bus.s_o), 32'd1);
        checkOutput("tt_111_c", 32'(bus.cout_o), 32'd1);
        checkOutput("tt_11_p", 32'(bus.p_o), 32'd0);
        checkOutput("tt_11_g", 32'(bus.g_o), 32'd1);
        bus.b_i = 0; bus.cin_i = 0;
        #1;
        checkOutput("tt_100_s", 32'(bus.s_o), 32'd1);
        checkOutput("tt_100_c", 32'(bus.cout_o), 32'd0);

        $display("[TB] pipelined mode");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("pipe_s", 32'(bus.s_q_o), 32'd0);
        checkOutput("pipe_cout", 32'(bus.cout_q_o), 32'd1);
        checkOutput("pipe_valid", 32'(bus.valid_o), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("pipe_hold_valid", 32'(bus.valid_o), 32'd0);
        checkOutput("pipe_hold_s", 32'(bus.s_q_o), 32'd0);
        checkOutput("pipe_hold_cout", 32'(bus.cout_q_o), 32'd1);

        $display("[TB] serial add and subtract");
        serialWord(8'h5A, 8'h3C, 1'b0);
        checkOutput("add_sum", 32'(wordResult), 32'h96);
        checkOutput("add_cout", 32'(bus.cout_q_o), 32'd0);
        serialWord(8'h05, ~8'h07, 1'b1);
        checkOutput("sub_5_7", 32'(wordResult), 32'hFE);
        checkOutput("sub_5_7_cout", 32'(bus.cout_q_o), 32'd0);
        serialWord(8'h07, ~8'h05, 1'b1);
        checkOutput("sub_7_5", 32'(wordResult), 32'h02);
        checkOutput("sub_7_5_cout", 32'(bus.cout_q_o), 32'd1);

        $display("[TB] clear without valid");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("clear_carry", 32'(dut.carry_q), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("clear_next_s", 32'(bus.s_q_o), 32'd0);

        $display("[TB] async reset mid word");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("pre_reset_carry", 32'(dut.carry_q), 32'd1);
        #2 rst_ni = 1'b0;
        #1;
        checkOutput("async_s", 32'(bus.s_q_o), 32'd0);
        checkOutput("async_cout", 32'(bus.cout_q_o), 32'd0);
        checkOutput("async_valid", 32'(bus.valid_o), 32'd0);
        checkOutput("async_carry", 32'(dut.carry_q), 32'd0);
        modelCarry = 1'b0; modelS = 1'b0; modelC = 1'b0;
        scoreboard.delete();
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        serialWord(8'h5A, 8'h3C, 1'b0);
        checkOutput("post_reset_sum", 32'(wordResult), 32'h96);
        checkOutput("post_reset_cout", 32'(bus.cout_q_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/full_adder_cell.md
Name: full_adder_cell

Overview:
Single-bit full adder for the calculator datapath. The combinational sum/carry outputs are the ripple-chain primitive used by the n-bit add/subtract blocks; subtraction is formed by inverting b and forcing carry-in to 1 at bit 0. A registered output stage with a carry register is added around the cell. It supports pipelined use and bit-serial add/subtract, one bit per valid cycle.

Parameters:
- REG_OUT, default 1: 1 = registered outputs active; 0 = s_q_o/cout_q_o/valid_o tied to 0 and carry register unused.

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  reset; one clock, reset asynchronous, active-low
- a_i  in  1  operand bit a
- b_i  in  1  operand bit b (caller pre-inverts for subtraction)
- cin_i  in  1  carry-in for the combinational path and for the first serial bit
- s_o  out  1  combinational sum
- cout_o  out  1  combinational carry-out
- p_o  out  1  propagate, a_i XOR b_i
- g_o  out  1  generate, a_i AND b_i
- valid_i  in  1  registered-path input qualifier
- serial_en_i  in  1  1 = registered path takes carry from internal carry register
- clear_i  in  1  start of serial word; sync clear of carry register
- s_q_o  out  1  registered sum
- cout_q_o  out  1  registered carry-out
- valid_o  out  1  registered-path output valid

Behaviour:
- Combinational path, always active, independent of clock, reset and mode:
  - s_o = a_i ^ b_i ^ cin_i
  - cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i))
  - p_o, g_o as defined in Ports.
  - Zero-delay truth table must hold for all 8 input combinations.
- Effective carry-in for the registered path: c_eff = (serial_en_i & ~clear_i) ? carry_q : cin_i.
- The registered path computes s_r = a_i ^ b_i ^ c_eff and c_r = majority(a_i, b_i, c_eff).
- On each rising edge with valid_i = 1:
  - s_q_o <= s_r
  - cout_q_o <= c_r
  - carry_q <= c_r
  - valid_o <= 1
- On a rising edge with valid_i = 0:
  - valid_o <= 0; s_q_o and cout_q_o hold.
  - If clear_i = 1, carry_q <= 0; otherwise carry_q holds.
- clear_i and valid_i together: the bit uses cin_i as carry-in (new word start), and carry_q <= c_r.
- Latency of the registered path is 1 cycle, with throughput of 1 bit per cycle. There is no backpressure.
- Reset, asynchronous on falling rst_ni, held while low: s_q_o = 0, cout_q_o = 0, valid_o = 0, carry_q = 0. The combinational outputs are unaffected by reset.
- Reset mid serial word: the word is aborted and carry_q = 0. The next word must be started with clear_i.
- Toggling serial_en_i mid-word is legal and takes effect on the current cycle's c_eff.
- REG_OUT = 0: registered outputs constant 0, and only the combinational outputs are functional.

Test Plan:
- Exhaustive combinational check over all 8 values of (a_i, b_i, cin_i) -> s_o/cout_o match the truth table. Example: 1,1,1 -> s=1, c=1; 1,0,0 -> s=1, c=0. Also check p_o/g_o: 1,1 -> p=0, g=1.
- Pipelined mode (serial_en_i = 0), valid_i = 1 with a=1, b=1, cin=0 -> one cycle later s_q_o=0, cout_q_o=1, valid_o=1. Then drop valid_i -> valid_o=0 next cycle, data held.
- Serial add 8'h5A + 8'h3C, LSB first, clear_i on bit 0, cin_i=0 -> s_q_o bit stream forms 8'h96, with final cout_q_o = 0.
- Serial subtract 8'h05 - 8'h07, with b inverted, clear_i on bit 0, cin_i=1 -> result bits 8'hFE, final cout_q_o = 0 (borrow). Then 8'h07 - 8'h05 -> 8'h02, final cout_q_o = 1.
- Assert rst_ni low mid serial word (carry_q = 1) -> outputs and carry_q go to 0 immediately, without waiting for a clock edge. Next word started with clear_i computes correctly.
- clear_i without valid_i after a word ending with carry 1 -> carry_q = 0. Then a serial bit with a=0, b=0, clear_i=0 -> s_q_o = 0.
